cpu_step_ctrl: RTL and testbench

- Parametrised run/step controller for the 16-bit pipelined core.
- Replaces hand-toggled clock sequences with a clock-enable generator. Modes: run exactly N cycles, single-step, free-run, halt.
- Stops on PC breakpoints and keeps a circular trace of (PC, fetched instruction) for every enabled cycle.
- Sits between the debug/host command source and the core's clock-enable input.

---
 rtl/cpu_dbg_pkg.sv | 20 ++
 rtl/step_trace_buf.sv | 56 +++++
 rtl/cpu_step_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-controller types: host command encodings and run states.
// Imported by the step controller and its trace buffer.
package cpu_dbg_pkg;

    localparam logic [1:0] CMD_RUN_N    = 2'd0;
    localparam logic [1:0] CMD_STEP     = 2'd1;
    localparam logic [1:0] CMD_RUN_FREE = 2'd2;
    localparam logic [1:0] CMD_HALT     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_CNT  = 2'd1,
        RUN_FREE = 2'd2
    } step_state_e;

    function automatic logic is_start(input logic [1:0] op);
        return op != CMD_HALT;
    endfunction

endpackage

// File: rtl/step_trace_buf.sv
// Circular (PC, instruction) trace with saturating count and a read port
// addressed relative to the oldest valid entry.
module step_trace_buf
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int INST_W      = 32,
    parameter int TRACE_DEPTH = 8,
    localparam int TW         = $clog2(TRACE_DEPTH),
    localparam int CW         = TW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    input  logic [TW-1:0]     i_rd_idx,
    output logic [PC_W-1:0]   o_rd_pc,
    output logic [INST_W-1:0] o_rd_inst,
    output logic [CW-1:0]     o_count
);

    localparam logic [CW-1:0] FULL = CW'(TRACE_DEPTH);

    logic [PC_W-1:0]   r_pc_mem   [TRACE_DEPTH];
    logic [INST_W-1:0] r_inst_mem [TRACE_DEPTH];
    logic [TW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     w_rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_we) begin
            r_wr_ptr <= r_wr_ptr + TW'(1);
            if (r_count != FULL)
                r_count <= r_count + CW'(1);
        end
    end

    // Storage carries no reset; contents are only meaningful below o_count.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_pc_mem[r_wr_ptr]   <= i_pc;
            r_inst_mem[r_wr_ptr] <= i_inst;
        end
    end

    // When full the low count bits are zero, so the oldest entry is wr_ptr.
    assign w_rd_addr = r_wr_ptr - r_count[TW-1:0] + i_rd_idx;
    assign o_rd_pc   = r_pc_mem[w_rd_addr];
    assign o_rd_inst = r_inst_mem[w_rd_addr];
    assign o_count   = r_count;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step clock-enable controller for the 16-bit core with PC
// breakpoints and a circular execution trace.
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int INST_W      = 32,
    parameter int CNT_W       = 16,
    parameter int NUM_BP      = 2,
    parameter int TRACE_DEPTH = 8,
    localparam int TW         = $clog2(TRACE_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_op,
    input  logic [CNT_W-1:0]       cmd_count,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [INST_W-1:0]      inst_in,
    output logic                   cpu_ce,
    output logic                   busy,
    output logic                   done,
    output logic                   bp_hit,
    output logic [2:0]             bp_idx,
    output logic                   cmd_err,
    input  logic [TW-1:0]          trace_rd_idx,
    output logic [PC_W-1:0]        trace_rd_pc,
    output logic [INST_W-1:0]      trace_rd_inst,
    output logic [TW:0]            trace_count
);

    step_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
    logic             r_first, w_first_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             r_bp_hit, w_bp_hit_nxt;
    logic [2:0]       r_bp_idx, w_bp_idx_nxt;

    logic             w_match;
    logic [2:0]       w_match_idx;
    logic             w_bp_stop;
    logic             w_start;
    logic             w_halt;
    logic             w_ce;
    logic [CNT_W-1:0] w_start_cnt;

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && pc_in == bp_addr[i*PC_W +: PC_W]) begin
                w_match     = 1'b1;
                w_match_idx = 3'(i);
            end
        end
    end

    assign w_bp_stop   = w_match && !r_first && (r_state != IDLE);
    assign w_start     = cmd_valid && is_start(cmd_op);
    assign w_halt      = cmd_valid && (cmd_op == CMD_HALT);
    assign w_start_cnt = (cmd_op == CMD_STEP) ? CNT_W'(1) : cmd_count;

    assign w_ce = !w_bp_stop &&
                  ((r_state == RUN_CNT && r_remaining != '0) ||
                   r_state == RUN_FREE);

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_first_nxt     = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_bp_hit_nxt    = r_bp_hit;
        w_bp_idx_nxt    = r_bp_idx;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_bp_hit_nxt = 1'b0;
                    if (cmd_op == CMD_RUN_FREE) begin
                        w_state_nxt = RUN_FREE;
                        w_first_nxt = 1'b1;
                    end else if (w_start_cnt == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = RUN_CNT;
                        w_remaining_nxt = w_start_cnt;
                        w_first_nxt     = 1'b1;
                    end
                end
            end
            RUN_CNT, RUN_FREE: begin
                w_err_nxt = w_start;
                if (w_bp_stop) begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = '0;
                    w_done_nxt      = 1'b1;
                    w_bp_hit_nxt    = 1'b1;
                    w_bp_idx_nxt    = w_match_idx;
                end else if (w_halt) begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = '0;
                    w_done_nxt      = 1'b1;
                end else if (r_state == RUN_CNT) begin
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_bp_idx    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_first     <= w_first_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_bp_hit    <= w_bp_hit_nxt;
            r_bp_idx    <= w_bp_idx_nxt;
        end
    end

    step_trace_buf #(
        .PC_W        (PC_W),
        .INST_W      (INST_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_ce),
        .i_pc      (pc_in),
        .i_inst    (inst_in),
        .i_rd_idx  (trace_rd_idx),
        .o_rd_pc   (trace_rd_pc),
        .o_rd_inst (trace_rd_inst),
        .o_count   (trace_count)
    );

    assign cpu_ce  = w_ce;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign bp_hit  = r_bp_hit;
    assign bp_idx  = r_bp_idx;
    assign cmd_err = r_err;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl; a tiny core model advances pc_in
// after every enabled cycle.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic [1:0]  bp_en;
    logic [31:0] bp_addr;
    logic [15:0] pc_in;
    logic [31:0] inst_in;
    logic        cpu_ce;
    logic        busy;
    logic        done;
    logic        bp_hit;
    logic [2:0]  bp_idx;
    logic        cmd_err;
    logic [2:0]  trace_rd_idx;
    logic [15:0] trace_rd_pc;
    logic [31:0] trace_rd_inst;
    logic [3:0]  trace_count;

    int n_pass = 0;
    int n_tot  = 0;
    logic last_ce = 1'b0;

    always #5 clk = ~clk;

    cpu_step_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_count     (cmd_count),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .pc_in         (pc_in),
        .inst_in       (inst_in),
        .cpu_ce        (cpu_ce),
        .busy          (busy),
        .done          (done),
        .bp_hit        (bp_hit),
        .bp_idx        (bp_idx),
        .cmd_err       (cmd_err),
        .trace_rd_idx  (trace_rd_idx),
        .trace_rd_pc   (trace_rd_pc),
        .trace_rd_inst (trace_rd_inst),
        .trace_count   (trace_count)
    );

    // Enter the next cycle: drop the strobe, advance the core if it ran.
    task automatic cyc();
        @(negedge clk);
        cmd_valid = 1'b0;
        if (last_ce) pc_in = pc_in + 16'd1;
        inst_in = {16'hC0DE, pc_in};
        #1;
        last_ce = cpu_ce;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
    endtask

    task automatic set_pc(input logic [15:0] pc);
        pc_in   = pc;
        inst_in = {16'hC0DE, pc};
        last_ce = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        last_ce = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        n_tot++;
        if ({cpu_ce, busy, done, bp_hit, cmd_err} !== 5'b0) begin
            $display("FAIL reset_flags got %b want 00000",
                     {cpu_ce, busy, done, bp_hit, cmd_err});
        end else n_pass++;
        n_tot++;
        if (bp_idx !== 3'd0 || trace_count !== 4'd0) begin
            $display("FAIL reset_idx_cnt got idx=%0d cnt=%0d want 0 0",
                     bp_idx, trace_count);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_run_n();
        set_pc(16'h0000);
        cyc();
        cmd(2'd0, 16'd5);
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tot++;
            if (cpu_ce !== (i < 5) || done !== (i == 5)) begin
                $display("FAIL run_n_c%0d got ce=%b done=%b want ce=%b done=%b",
                         i, cpu_ce, done, i < 5, i == 5);
            end else n_pass++;
        end
        n_tot++;
        if (trace_count !== 4'd5) begin
            $display("FAIL run_n_count got %0d want 5", trace_count);
        end else n_pass++;
        trace_rd_idx = 3'd0;
        #1;
        n_tot++;
        if (trace_rd_pc !== 16'h0000) begin
            $display("FAIL run_n_idx0 got %h want 0000", trace_rd_pc);
        end else n_pass++;
        trace_rd_idx = 3'd4;
        #1;
        n_tot++;
        if (trace_rd_pc !== 16'h0004 || trace_rd_inst !== 32'hC0DE0004) begin
            $display("FAIL run_n_idx4 got %h/%h want 0004/c0de0004",
                     trace_rd_pc, trace_rd_inst);
        end else n_pass++;
    endtask

    task automatic test_breakpoint();
        set_pc(16'h0000);
        bp_en   = 2'b11;
        bp_addr = {16'h0006, 16'h0006};
        cyc();
        cmd(2'd2, 16'd0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tot++;
            if (cpu_ce !== (i < 6) || done !== (i == 7)) begin
                $display("FAIL bp_c%0d got ce=%b done=%b want ce=%b done=%b",
                         i, cpu_ce, done, i < 6, i == 7);
            end else n_pass++;
        end
        n_tot++;
        if (bp_hit !== 1'b1 || bp_idx !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL bp_hit got hit=%b idx=%0d busy=%b want 1 0 0",
                     bp_hit, bp_idx, busy);
        end else n_pass++;
        cmd(2'd1, 16'd0);
        cyc();
        n_tot++;
        if (cpu_ce !== 1'b1 || pc_in !== 16'h0006 || bp_hit !== 1'b0) begin
            $display("FAIL step_resume got ce=%b pc=%h hit=%b want 1 0006 0",
                     cpu_ce, pc_in, bp_hit);
        end else n_pass++;
        cyc();
        n_tot++;
        if (cpu_ce !== 1'b0 || done !== 1'b1) begin
            $display("FAIL step_end got ce=%b done=%b want 0 1", cpu_ce, done);
        end else n_pass++;
        bp_en = 2'b00;
    endtask

    task automatic test_wrap();
        do_reset();
        set_pc(16'h0010);
        cyc();
        cmd(2'd0, 16'd12);
        for (int i = 0; i < 13; i++) cyc();
        n_tot++;
        if (trace_count !== 4'd8 || done !== 1'b1) begin
            $display("FAIL wrap_count got cnt=%0d done=%b want 8 1",
                     trace_count, done);
        end else n_pass++;
        trace_rd_idx = 3'd0;
        #1;
        n_tot++;
        if (trace_rd_pc !== 16'h0014) begin
            $display("FAIL wrap_idx0 got %h want 0014", trace_rd_pc);
        end else n_pass++;
        trace_rd_idx = 3'd7;
        #1;
        n_tot++;
        if (trace_rd_pc !== 16'h001B) begin
            $display("FAIL wrap_idx7 got %h want 001b", trace_rd_pc);
        end else n_pass++;
        trace_rd_idx = 3'd3;
        #1;
        n_tot++;
        if (trace_rd_inst !== 32'hC0DE0017) begin
            $display("FAIL wrap_idx3 got %h want c0de0017", trace_rd_inst);
        end else n_pass++;
    endtask

    task automatic test_zero_and_err();
        int ce_n;
        int done_at;
        cyc();
        cmd(2'd0, 16'd0);
        cyc();
        n_tot++;
        if (cpu_ce !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL cnt0 got ce=%b done=%b busy=%b want 0 1 0",
                     cpu_ce, done, busy);
        end else n_pass++;
        cyc();
        n_tot++;
        if (done !== 1'b0 || cpu_ce !== 1'b0) begin
            $display("FAIL cnt0_after got done=%b ce=%b want 0 0", done, cpu_ce);
        end else n_pass++;
        cmd(2'd0, 16'd100);
        cyc();
        ce_n = cpu_ce ? 1 : 0;
        cmd(2'd2, 16'd0);
        cyc();
        ce_n += cpu_ce ? 1 : 0;
        n_tot++;
        if (cmd_err !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL cmd_err got err=%b busy=%b want 1 1", cmd_err, busy);
        end else n_pass++;
        done_at = -1;
        for (int i = 0; i < 120 && done_at < 0; i++) begin
            cyc();
            if (cpu_ce) ce_n++;
            if (done) done_at = i;
        end
        n_tot++;
        if (ce_n !== 100 || done_at < 0) begin
            $display("FAIL err_run got ce_cycles=%0d done_seen=%0d want 100 1",
                     ce_n, done_at >= 0);
        end else n_pass++;
    endtask

    task automatic test_halt();
        cyc();
        cmd(2'd2, 16'd0);
        cyc();
        cyc();
        n_tot++;
        if (cpu_ce !== 1'b1) begin
            $display("FAIL halt_lastce got ce=%b want 1", cpu_ce);
        end else n_pass++;
        cmd(2'd3, 16'd0);
        cyc();
        n_tot++;
        if (cpu_ce !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || bp_hit !== 1'b0) begin
            $display("FAIL halt got ce=%b done=%b busy=%b hit=%b want 0 1 0 0",
                     cpu_ce, done, busy, bp_hit);
        end else n_pass++;
        cmd(2'd3, 16'd0);
        cyc();
        cyc();
        n_tot++;
        if (done !== 1'b0 || cmd_err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL halt_idle got done=%b err=%b busy=%b want 0 0 0",
                     done, cmd_err, busy);
        end else n_pass++;
        set_pc(16'h0040);
        bp_en   = 2'b10;
        bp_addr = {16'h0043, 16'h0000};
        cyc();
        cmd(2'd2, 16'd0);
        for (int i = 0; i < 4; i++) cyc();
        n_tot++;
        if (pc_in !== 16'h0043 || cpu_ce !== 1'b0) begin
            $display("FAIL halt_bp_stop got pc=%h ce=%b want 0043 0", pc_in, cpu_ce);
        end else n_pass++;
        cmd(2'd3, 16'd0);
        cyc();
        n_tot++;
        if (bp_hit !== 1'b1 || bp_idx !== 3'd1 || done !== 1'b1) begin
            $display("FAIL halt_bp got hit=%b idx=%0d done=%b want 1 1 1",
                     bp_hit, bp_idx, done);
        end else n_pass++;
        bp_en = 2'b00;
    endtask

    task automatic test_reset_mid_run();
        cyc();
        cmd(2'd2, 16'd0);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_tot++;
        if (cpu_ce !== 1'b0 || busy !== 1'b0 || trace_count !== 4'd0) begin
            $display("FAIL rst_mid got ce=%b busy=%b cnt=%0d want 0 0 0",
                     cpu_ce, busy, trace_count);
        end else n_pass++;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_tot++;
        if (done !== 1'b0 || cpu_ce !== 1'b0) begin
            $display("FAIL rst_mid_done got done=%b ce=%b want 0 0", done, cpu_ce);
        end else n_pass++;
    endtask

    initial begin
        cmd_valid    = 1'b0;
        cmd_op       = 2'd0;
        cmd_count    = 16'd0;
        bp_en        = 2'b00;
        bp_addr      = 32'd0;
        pc_in        = 16'd0;
        inst_in      = 32'd0;
        trace_rd_idx = 3'd0;
        test_reset();
        test_run_n();
        test_breakpoint();
        test_wrap();
        test_zero_and_err();
        test_halt();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
